// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 RGB LED matrix scan driver.
// One packed row carries the red, green and blue column bits for a single matrix row.
package led_matrix_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam logic [ROWS-1:0] ROW_IDLE = 8'hFF;

    typedef struct packed {
        logic [COLS-1:0] r;
        logic [COLS-1:0] g;
        logic [COLS-1:0] b;
    } rgb_row_t;

    // Active-low one-hot select for the given row.
    function automatic logic [ROWS-1:0] row_select(input logic [2:0] idx);
        logic [ROWS-1:0] one_hot;
        one_hot      = '0;
        one_hot[idx] = 1'b1;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Row-write and commit bus between a pattern generator (master) and the scan driver (slave).
interface led_matrix_scan_if;
    import led_matrix_pkg::*;

    logic            wr_valid;
    logic            wr_ready;
    logic [2:0]      wr_row;
    logic [COLS-1:0] wr_r;
    logic [COLS-1:0] wr_g;
    logic [COLS-1:0] wr_b;
    logic            commit;
    logic            commit_pending;

    modport master (
        output wr_valid, wr_row, wr_r, wr_g, wr_b, commit,
        input  wr_ready, commit_pending
    );

    modport slave (
        input  wr_valid, wr_row, wr_r, wr_g, wr_b, commit,
        output wr_ready, commit_pending
    );

endinterface

// File: rtl/led_frame_buf.sv
// Ping-pong frame store: writes land in the back bank, the display reads the front bank.
// A swap flips the roles; neither bank is cleared, so the new back bank keeps the old frame.
module led_frame_buf
    import led_matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  rgb_row_t   wr_data,
    input  logic       swap,
    input  logic [2:0] rd_row,
    output rgb_row_t   rd_data
);

    rgb_row_t bank [2][ROWS];
    logic     front_sel;

    // A write and a swap on the same edge put the written row into the new front frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            front_sel <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < ROWS; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                bank[~front_sel][wr_row] <= wr_data;
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    assign rd_data = bank[front_sel][rd_row];

endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed scan driver for the 8x8 RGB matrix: slot counter, row counter,
// frame-boundary commit handling and registered pin drive with per-slot blanking.
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV = 50,
    parameter int BLANK    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    led_matrix_scan_if.slave        wr_bus,
    output logic                    frame_start,
    output logic [ROWS-1:0]         led_row,
    output logic [COLS-1:0]         led_col_r,
    output logic [COLS-1:0]         led_col_g,
    output logic [COLS-1:0]         led_col_b
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       row_idx;
    logic             commit_pending;
    logic             row_end;
    logic             frame_end;
    logic             wr_en;
    logic             swap;
    rgb_row_t         wr_data;
    rgb_row_t         front_row;

    assign row_end   = (cnt == CNT_LAST);
    assign frame_end = row_end && (row_idx == 3'(ROWS - 1));
    assign wr_en     = wr_bus.wr_valid && !commit_pending;
    assign swap      = frame_end && (commit_pending || wr_bus.commit);
    assign wr_data   = {wr_bus.wr_r, wr_bus.wr_g, wr_bus.wr_b};

    assign wr_bus.wr_ready       = ~commit_pending;
    assign wr_bus.commit_pending = commit_pending;

    led_frame_buf u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_bus.wr_row),
        .wr_data (wr_data),
        .swap    (swap),
        .rd_row  (row_idx),
        .rd_data (front_row)
    );

    // Outputs decode the pre-edge counters, so the pins trail the scan counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            row_idx        <= '0;
            commit_pending <= 1'b0;
            frame_start    <= 1'b0;
            led_row        <= ROW_IDLE;
            led_col_r      <= '0;
            led_col_g      <= '0;
            led_col_b      <= '0;
        end else begin
            cnt <= row_end ? '0 : cnt + 1'b1;
            if (row_end) begin
                row_idx <= row_idx + 3'd1;
            end

            if (swap) begin
                commit_pending <= 1'b0;
            end else if (wr_bus.commit) begin
                commit_pending <= 1'b1;
            end

            frame_start <= frame_end;

            if (cnt < CNT_BLANK) begin
                led_row   <= ROW_IDLE;
                led_col_r <= '0;
                led_col_g <= '0;
                led_col_b <= '0;
            end else begin
                led_row   <= row_select(row_idx);
                led_col_r <= front_row.r;
                led_col_g <= front_row.g;
                led_col_b <= front_row.b;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: an edge-count reference model predicts every
// pin from the frame timing rules while directed and random writes/commits are applied.
module tb_led_matrix_scan;

    localparam int SD    = 10;
    localparam int BL    = 2;
    localparam int FRAME = 8 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic [7:0] led_row, led_col_r, led_col_g, led_col_b;

    led_matrix_scan_if bus ();

    led_matrix_scan #(.SCAN_DIV(SD), .BLANK(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_bus      (bus),
        .frame_start (frame_start),
        .led_row     (led_row),
        .led_col_r   (led_col_r),
        .led_col_g   (led_col_g),
        .led_col_b   (led_col_b)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          n;
    logic [23:0] front_m [8];
    logic [23:0] back_m  [8];
    bit          pending_m;
    logic [7:0]  exp_row, exp_r, exp_g, exp_b;
    bit          exp_fs;

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_row   = 3'd0;
        bus.wr_r     = 8'h00;
        bus.wr_g     = 8'h00;
        bus.wr_b     = 8'h00;
        bus.commit   = 1'b0;
    endtask

    // Reference model: n counts active edges since reset; the slot and row shown after
    // an edge follow directly from the pre-edge edge count.
    task automatic tick();
        int          c, r;
        bit          bnd;
        logic [23:0] t;
        @(posedge clk);
        if (rst) begin
            n         = 0;
            pending_m = 1'b0;
            for (int i = 0; i < 8; i++) begin
                front_m[i] = '0;
                back_m[i]  = '0;
            end
            exp_row = 8'hFF;
            {exp_r, exp_g, exp_b} = '0;
            exp_fs  = 1'b0;
        end else begin
            c   = n % SD;
            r   = (n / SD) % 8;
            bnd = ((n + 1) % FRAME) == 0;
            if (c < BL) begin
                exp_row = 8'hFF;
                {exp_r, exp_g, exp_b} = '0;
            end else begin
                exp_row = ~(8'h01 << r);
                {exp_r, exp_g, exp_b} = front_m[r];
            end
            exp_fs = bnd;
            if (bus.wr_valid && !pending_m) begin
                back_m[bus.wr_row] = {bus.wr_r, bus.wr_g, bus.wr_b};
            end
            if (bnd && (pending_m || bus.commit)) begin
                for (int i = 0; i < 8; i++) begin
                    t          = front_m[i];
                    front_m[i] = back_m[i];
                    back_m[i]  = t;
                end
                pending_m = 1'b0;
            end else if (bus.commit) begin
                pending_m = 1'b1;
            end
            n++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (led_row !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_row got=%h expected=ff", led_row);
        end
        checks++;
        if ({led_col_r, led_col_g, led_col_b} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_cols got=%h_%h_%h expected=0", led_col_r, led_col_g, led_col_b);
        end
        checks++;
        if ({bus.wr_ready, bus.commit_pending, frame_start} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_flags got ready/pend/fs=%b%b%b expected=100",
                     bus.wr_ready, bus.commit_pending, frame_start);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan();
        int fs_count = 0;
        while (n < 2 * FRAME + 5) begin
            tick();
            if (frame_start === 1'b1) fs_count++;
            checks++;
            if ({led_row, led_col_r, led_col_g, led_col_b, frame_start} !==
                {exp_row, exp_r, exp_g, exp_b, exp_fs}) begin
                errors++;
                $display("[TB] FAIL idle_scan n=%0d got row=%h rgb=%h_%h_%h fs=%b expected row=%h rgb=%h_%h_%h fs=%b",
                         n, led_row, led_col_r, led_col_g, led_col_b, frame_start,
                         exp_row, exp_r, exp_g, exp_b, exp_fs);
            end
            checks++;
            if ((n == 3 && led_row !== 8'hFE) || (n == 13 && led_row !== 8'hFD) ||
                (n == 11 && led_row !== 8'hFF)) begin
                errors++;
                $display("[TB] FAIL idle_sequence n=%0d got row=%h", n, led_row);
            end
        end
        checks++;
        if (fs_count !== 2) begin
            errors++;
            $display("[TB] FAIL frame_start_count got=%0d expected=2", fs_count);
        end
    endtask

    task automatic test_commit_row3();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        while (n < 4) tick();
        bus.wr_valid = 1'b1;
        bus.wr_row   = 3'd3;
        bus.wr_r     = 8'hA5;
        bus.commit   = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if ({bus.commit_pending, bus.wr_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL commit_armed got pend/ready=%b%b expected=10",
                     bus.commit_pending, bus.wr_ready);
        end
        while (n < 2 * FRAME + 10) begin
            tick();
            checks++;
            if ({led_row, led_col_r, led_col_g, led_col_b, frame_start, bus.wr_ready, bus.commit_pending} !==
                {exp_row, exp_r, exp_g, exp_b, exp_fs, ~pending_m, pending_m}) begin
                errors++;
                $display("[TB] FAIL commit_row3 n=%0d got row=%h r=%h pend=%b expected row=%h r=%h pend=%b",
                         n, led_row, led_col_r, bus.commit_pending, exp_row, exp_r, pending_m);
            end
            if (n == 79 || n == 80 || n == 83 || n == 113) begin
                checks++;
                if ((n == 79 && bus.commit_pending !== 1'b1) ||
                    (n == 80 && {bus.commit_pending, bus.wr_ready} !== 2'b01) ||
                    (n == 83 && {led_row, led_col_r} !== 16'hFE00) ||
                    (n == 113 && {led_row, led_col_r} !== 16'hF7A5)) begin
                    errors++;
                    $display("[TB] FAIL commit_row3_point n=%0d got row=%h r=%h pend=%b ready=%b",
                             n, led_row, led_col_r, bus.commit_pending, bus.wr_ready);
                end
            end
        end
    endtask

    task automatic test_write_while_pending();
        while (n < 5 * FRAME) begin
            idle_inputs();
            if (n == 171 || n == 199 || n == 249) bus.commit = 1'b1;
            if (n >= 180 && n < 190) begin
                bus.wr_valid = 1'b1;
                bus.wr_row   = 3'd5;
                bus.wr_r     = 8'($urandom);
                bus.wr_g     = 8'($urandom);
                bus.wr_b     = 8'($urandom) | 8'h01;
            end
            tick();
            checks++;
            if ({led_row, led_col_r, led_col_g, led_col_b, frame_start, bus.wr_ready, bus.commit_pending} !==
                {exp_row, exp_r, exp_g, exp_b, exp_fs, ~pending_m, pending_m}) begin
                errors++;
                $display("[TB] FAIL write_pending n=%0d got row=%h rgb=%h_%h_%h ready=%b expected row=%h rgb=%h_%h_%h ready=%b",
                         n, led_row, led_col_r, led_col_g, led_col_b, bus.wr_ready,
                         exp_row, exp_r, exp_g, exp_b, ~pending_m);
            end
            if (n == 185 || n == 353 || n == 373) begin
                checks++;
                if ((n == 185 && bus.wr_ready !== 1'b0) ||
                    (n == 353 && {led_row, led_col_r} !== 16'hF7A5) ||
                    (n == 373 && {led_row, led_col_r, led_col_g, led_col_b} !== 32'hDF000000)) begin
                    errors++;
                    $display("[TB] FAIL write_pending_point n=%0d got row=%h rgb=%h_%h_%h ready=%b",
                             n, led_row, led_col_r, led_col_g, led_col_b, bus.wr_ready);
                end
            end
        end
    endtask

    task automatic test_boundary_commit();
        idle_inputs();
        while (n < 6 * FRAME - 1) tick();
        bus.commit   = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_row   = 3'd0;
        bus.wr_g     = 8'h0F;
        tick();
        idle_inputs();
        checks++;
        if ({bus.commit_pending, frame_start} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL boundary_swap got pend/fs=%b%b expected=01", bus.commit_pending, frame_start);
        end
        while (n < 6 * FRAME + 20) begin
            tick();
            checks++;
            if ({led_row, led_col_r, led_col_g, led_col_b, bus.commit_pending} !==
                {exp_row, exp_r, exp_g, exp_b, pending_m}) begin
                errors++;
                $display("[TB] FAIL boundary_commit n=%0d got row=%h g=%h expected row=%h g=%h",
                         n, led_row, led_col_g, exp_row, exp_g);
            end
            if (n == 6 * FRAME + BL + 1) begin
                checks++;
                if ({led_row, led_col_g} !== 16'hFE0F) begin
                    errors++;
                    $display("[TB] FAIL boundary_latency got row=%h g=%h expected row=fe g=0f", led_row, led_col_g);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        while (n < 7 * FRAME + 45) begin
            idle_inputs();
            if (n == 7 * FRAME + 40) bus.commit = 1'b1;
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        checks++;
        if ({led_row, led_col_r, led_col_g, led_col_b, bus.commit_pending} !== {8'hFF, 24'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid got row=%h rgb=%h_%h_%h pend=%b expected row=ff rgb=0 pend=0",
                     led_row, led_col_r, led_col_g, led_col_b, bus.commit_pending);
        end
        rst = 1'b0;
        while (n < FRAME + 10) begin
            tick();
            checks++;
            if ({led_col_r, led_col_g, led_col_b} !== 24'h0 || led_row !== exp_row ||
                frame_start !== exp_fs) begin
                errors++;
                $display("[TB] FAIL dark_after_reset n=%0d got row=%h rgb=%h_%h_%h fs=%b expected row=%h rgb=0 fs=%b",
                         n, led_row, led_col_r, led_col_g, led_col_b, frame_start, exp_row, exp_fs);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8 * FRAME; k++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_row   = 3'($urandom_range(0, 7));
            bus.wr_r     = 8'($urandom);
            bus.wr_g     = 8'($urandom);
            bus.wr_b     = 8'($urandom);
            bus.commit   = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if ({led_row, led_col_r, led_col_g, led_col_b, frame_start, bus.wr_ready, bus.commit_pending} !==
                {exp_row, exp_r, exp_g, exp_b, exp_fs, ~pending_m, pending_m}) begin
                errors++;
                $display("[TB] FAIL random n=%0d got row=%h rgb=%h_%h_%h fs=%b pend=%b expected row=%h rgb=%h_%h_%h fs=%b pend=%b",
                         n, led_row, led_col_r, led_col_g, led_col_b, frame_start, bus.commit_pending,
                         exp_row, exp_r, exp_g, exp_b, exp_fs, pending_m);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n         = 0;
        pending_m = 1'b0;
        rst       = 1'b1;
        idle_inputs();
        test_reset();
        test_idle_scan();
        test_commit_row3();
        test_write_while_pending();
        test_boundary_commit();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-multiplexing scan driver for the 8×8 RGB LED matrix. It sits directly downstream of the pattern generators (Marquee and similar), which write 8-pixel rows into a back buffer and commit whole frames. The block displays the front buffer one row at a time, with blanking between rows to suppress ghosting. It drives the board pins `led_row` and `led_col_r/g/b` directly.

## Interface
- `SCAN_DIV`, 50: clocks per row slot, blanking included; legal range ≥ BLANK+1.
- `BLANK`, 2: clocks at the start of each slot with all rows and columns off; legal range ≥ 1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: row-write request.
- `wr_ready` out 1: back buffer accepts writes.
- `wr_row` in 3: row index to write.
- `wr_r`, `wr_g`, `wr_b` in 8 each: column bits for that row; bit i is column i; 1 = lit.
- `commit` in 1: one-cycle request to swap buffers at the next frame boundary.
- `commit_pending` out 1: a swap is armed and not yet performed.
- `frame_start` out 1: one-cycle pulse when row 0 becomes the current row.
- `led_row` out 8: row select, one-hot active-low; idle value 8'hFF.
- `led_col_r`, `led_col_g`, `led_col_b` out 8 each: column drive, active-high.

## Operation
- Two 8×24-bit banks, front and back. Writes go only to the back bank. Display reads only the front bank.
- Write handshake: a write is accepted on an edge where `wr_valid && wr_ready`, and it overwrites the whole row `wr_row`. `wr_ready = ~commit_pending`.
- A write accepted on the same edge as `commit` is included in the committed frame.
- `commit` while `commit_pending` is already set is ignored.
- Scan counter `cnt` counts 0..SCAN_DIV-1 and wraps. `row_idx` (0..7) increments on each wrap, 7 wraps to 0.
- Frame boundary: the edge where `cnt==SCAN_DIV-1 && row_idx==7`.
- At the frame boundary, if `commit_pending` or `commit` is set:
  - swap the banks (ping-pong; the new back bank keeps the old front content and is not cleared);
  - clear `commit_pending`.
- Otherwise, `commit` sets `commit_pending`.
- Output decode from the pre-edge `cnt`:
  - `cnt < BLANK`: `led_row=8'hFF`, columns = 0.
  - Otherwise: `led_row = ~(1<<row_idx)`, columns = front[row_idx] RGB.
- `frame_start` is asserted for the one cycle after the edge where `row_idx` wraps 7→0.
- Reset values:
  - `cnt=0`, `row_idx=0`, both banks all 0, bank select 0;
  - `led_row=8'hFF`, all columns 0;
  - `wr_ready=1`, `commit_pending=0`, `frame_start=0`.
- Reset mid-frame aborts immediately. Pending commits and buffered writes are discarded, and no partial row remains driven.

## Timing
- All outputs are registered and lag the scan counter by one cycle.
- Edge n = nth rising edge with `rst` low.
  - After edge n: `cnt = n mod SCAN_DIV`.
  - Outputs after edge n reflect `cnt = (n-1) mod SCAN_DIV`.
- First active output, row 0 (`led_row=8'hFE`), appears after edge BLANK+1. It holds SCAN_DIV-BLANK cycles, then blanks for BLANK cycles.
- Row period = SCAN_DIV cycles. Frame period = 8·SCAN_DIV cycles.
- Commit → display latency: the new frame's row 0 is lit BLANK+1 edges after the frame-boundary edge.
- `wr_ready` deasserts the cycle after a commit is armed. It reasserts the cycle after the swap edge.

## Structure
- Package `led_matrix_pkg`:
  - `ROWS=8`, `COLS=8`, `ROW_IDLE=8'hFF`;
  - typedef `rgb_row_t` (r,g,b ×8 bits).
- Sub-module `led_frame_buf`: two banks, bank-select flop, a write port on the back bank, a read port on the front bank indexed by `row_idx`, and a `swap` input.
- `led_matrix_scan` holds the counters, commit logic and output registers.

## Test plan
Parameters: SCAN_DIV=10, BLANK=2.
- Reset, then idle:
  - `led_row` goes FF, FE, FD, … with the two blank cycles per slot;
  - columns stay 0;
  - `frame_start` pulses every 80 cycles.
- Write row 3 with r=8'hA5 and commit at cycle 5:
  - `commit_pending=1` and `wr_ready=0` until the boundary at edge 80;
  - row 0 outputs blank in the next frame;
  - at `led_row=8'hF7`, `led_col_r=8'hA5`.
- Assert `wr_valid` while pending: no handshake, and the back bank is unchanged. A second commit while pending causes no extra swap.
- `commit` and a write to row 0 (g=8'h0F) on the exact boundary edge:
  - the swap happens at that edge;
  - `led_col_g=8'h0F` at `led_row=8'hFE`, BLANK+1 edges later.
- Assert `rst` mid-row 4 with a commit pending:
  - the next cycle shows `led_row=8'hFF`, columns 0, `commit_pending=0`;
  - after release, the display is all dark (banks cleared).
